// File: rtl/axis_fifo_pkt_pkg.sv
// Shared sizing helpers and configuration sanity check for the packet-aware stream FIFO.
package axis_fifo_pkt_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Level counts up to DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(input int unsigned depth,
                                input int unsigned ae_level,
                                input int unsigned af_level);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/axis_fifo_pkt_sdp_ram.sv
// Simple dual-port RAM, 1-cycle registered read; the read register holds while rd_en is low.
// Only the read register is reset so the array maps onto block RAM.
module axis_fifo_pkt_sdp_ram #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO, TLAST per word, FWFT: a push into an empty FIFO shows on m_valid 2 cycles later.
// s_ready drops only when full; output word holds while stalled; optional store-and-forward gating.
module axis_fifo_pkt
  import axis_fifo_pkt_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned AF_LEVEL    = 3072,
  parameter int unsigned AE_LEVEL    = 16,
  parameter bit          PACKET_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  if (!cfg_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_cfg
    $error("axis_fifo_pkt: need DEPTH power of 2 >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] ram_cnt, pkt_cnt, level_nxt;
  logic             push, pop, rd_en, release_ok;
  word_t            wr_word, rd_word;

  assign s_ready = !full && !rst;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign wr_word = {s_last, s_data};
  assign m_data  = rd_word.data;
  assign m_last  = rd_word.last;

  // In packet mode only release words that belong to a fully stored packet, not counting
  // the one leaving now; a full FIFO with no complete packet releases anyway to avoid deadlock.
  always_comb begin
    release_ok = 1'b1;
    if (PACKET_MODE)
      release_ok = (pkt_cnt > LVL_W'(pop && m_last)) || (full && pkt_cnt == '0);
  end

  // The RAM read register is the output register; refill it whenever it empties or is popped.
  assign rd_en = (ram_cnt != '0) && (!m_valid || pop) && release_ok;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  axis_fifo_pkt_sdp_ram #(
    .WIDTH  ($bits(word_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      pkt_cnt      <= '0;
      m_valid      <= 1'b0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;

      if (push && !rd_en)
        ram_cnt <= ram_cnt + 1'b1;
      else if (rd_en && !push)
        ram_cnt <= ram_cnt - 1'b1;

      if (rd_en)
        m_valid <= 1'b1;
      else if (pop)
        m_valid <= 1'b0;

      if ((push && s_last) && !(pop && m_last))
        pkt_cnt <= pkt_cnt + 1'b1;
      else if ((pop && m_last) && !(push && s_last))
        pkt_cnt <= pkt_cnt - 1'b1;

      level        <= level_nxt;
      full         <= (level_nxt == LVL_W'(DEPTH));
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= LVL_W'(AF_LEVEL));
      almost_empty <= (level_nxt <= LVL_W'(AE_LEVEL));
    end
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed bench for axis_fifo_pkt: streaming instance plus a packet-mode instance, with a
// queue scoreboard that tracks expected contents, level and flags every cycle.
module tb_axis_fifo_pkt;

  localparam int DW    = 16;
  localparam int DEPTH = 4096;
  localparam int LW    = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data = '0, m_data;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic          m_valid, m_last, m_ready = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full, almost_empty, full, empty;

  logic [DW-1:0] p_s_data = '0, p_m_data;
  logic          p_s_valid = 1'b0, p_s_last = 1'b0, p_s_ready;
  logic          p_m_valid, p_m_last, p_m_ready = 1'b0;
  logic [LW-1:0] p_level;
  logic          p_almost_full, p_almost_empty, p_full, p_empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] pkt_out[$];

  axis_fifo_pkt dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .full(full), .empty(empty)
  );

  axis_fifo_pkt #(.PACKET_MODE(1'b1)) dut_pkt (
    .clk(clk), .rst(rst),
    .s_data(p_s_data), .s_valid(p_s_valid), .s_last(p_s_last), .s_ready(p_s_ready),
    .m_data(p_m_data), .m_valid(p_m_valid), .m_last(p_m_last), .m_ready(p_m_ready),
    .level(p_level), .almost_full(p_almost_full), .almost_empty(p_almost_empty),
    .full(p_full), .empty(p_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard sampled mid-cycle: state after the last edge must match the model, then
  // the handshakes that the next edge will complete update the model.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    check("level_model", 32'(level), 32'(sz));
    check("flags_model", 32'({full, empty, almost_full, almost_empty}),
          32'({sz == DEPTH, sz == 0, sz >= 3072, sz <= 16}));
    check("s_ready_model", 32'(s_ready), 32'(!rst && sz != DEPTH));
    if (rst) begin
      exp_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (sz == 0)
          check("pop_extra", 32'(1), 32'(0));
        else
          check("pop_word", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      if (s_valid && s_ready)
        exp_q.push_back({s_last, s_data});
    end
  end

  always @(negedge clk) begin
    if (!rst && p_m_valid && p_m_ready)
      pkt_out.push_back({p_m_last, p_m_data});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    int   guard;
    int   t3_push;
    logic acc;

    // Reset values
    repeat (3) tick();
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_data", 32'({m_last, m_data}), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_flags", 32'({full, empty, almost_full, almost_empty}), 32'(4'b0101));
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 32'(1));

    // Basic ordering and first-word latency
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0;
    tick();
    check("lat_cycle1", 32'(m_valid), 32'(0));
    s_data = 16'h0002;
    tick();
    check("lat_cycle2", 32'(m_valid), 32'(1));
    check("first_data", 32'(m_data), 32'h0001);
    s_data = 16'h0003;
    tick();
    s_data = 16'h0004; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) tick();
    check("t1_drained", 32'(exp_q.size()), 32'(0));
    check("t1_empty", 32'(empty), 32'(1));

    // Backpressure: output word held while stalled
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'hABCD; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(m_valid), 32'(1));
      check("bp_data", 32'({m_last, m_data}), 32'h1ABCD);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    check("bp_popped", 32'(m_valid), 32'(0));

    // Fill to capacity with the consumer stalled
    cnt = 0;
    guard = 0;
    s_valid = 1'b1;
    while (cnt < DEPTH && guard < DEPTH + 100) begin
      s_data = 16'(16'h1000 + cnt);
      acc = s_ready;
      tick();
      guard++;
      if (acc) begin
        cnt++;
        if (cnt == 16)   check("ae_at_16", 32'(almost_empty), 32'(1));
        if (cnt == 17)   check("ae_at_17", 32'(almost_empty), 32'(0));
        if (cnt == 3071) check("af_at_3071", 32'(almost_full), 32'(0));
        if (cnt == 3072) check("af_at_3072", 32'(almost_full), 32'(1));
      end
    end
    check("fill_count", 32'(cnt), 32'(DEPTH));
    check("fill_full", 32'(full), 32'(1));
    check("fill_s_ready", 32'(s_ready), 32'(0));
    check("fill_level", 32'(level), 32'(DEPTH));
    s_data = 16'hFFFF;
    tick();
    check("full_no_push", 32'(level), 32'(DEPTH));
    check("full_head", 32'(m_data), 32'h1000);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pop_level", 32'(level), 32'(DEPTH - 1));
    check("pop_s_ready", 32'(s_ready), 32'(1));
    check("pop_full", 32'(full), 32'(0));

    // Streaming with random consumer across several pointer wraps
    t3_push = 0;
    s_valid = 1'b1;
    s_data = 16'h2000;
    for (int i = 0; i < 28000; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      acc = s_ready;
      tick();
      if (acc) begin
        t3_push++;
        s_data = s_data + 1'b1;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    guard = 0;
    while (!empty && guard < 5000) begin
      tick();
      guard++;
    end
    m_ready = 1'b0;
    check("wrap_passes", 32'(t3_push >= 3 * DEPTH), 32'(1));
    check("stream_drained", 32'(empty), 32'(1));
    check("stream_model_empty", 32'(exp_q.size()), 32'(0));

    // Reset mid-burst
    cnt = 0;
    guard = 0;
    s_valid = 1'b1;
    while (cnt < 100 && guard < 300) begin
      s_data = 16'(16'h3000 + cnt);
      acc = s_ready;
      tick();
      guard++;
      if (acc) cnt++;
    end
    check("pre_rst_level", 32'(level), 32'(100));
    rst = 1'b1;
    tick();
    check("mid_rst_level", 32'(level), 32'(0));
    check("mid_rst_empty", 32'(empty), 32'(1));
    check("mid_rst_m_valid", 32'(m_valid), 32'(0));
    rst = 1'b0;
    s_data = 16'h5A5A; s_last = 1'b1;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    check("after_rst_valid", 32'(m_valid), 32'(1));
    check("after_rst_word", 32'({m_last, m_data}), 32'h15A5A);
    tick();
    m_ready = 1'b0;
    tick();

    // Packet mode: hold output until the packet's last word is stored
    pkt_out.delete();
    p_m_ready = 1'b1;
    p_s_valid = 1'b1;
    p_s_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      p_s_data = 16'(16'h0100 + i);
      tick();
      check("pkt_hold_valid", 32'(p_m_valid), 32'(0));
    end
    p_s_valid = 1'b0;
    repeat (4) tick();
    check("pkt_hold_valid2", 32'(p_m_valid), 32'(0));
    check("pkt_hold_level", 32'(p_level), 32'(10));
    p_s_valid = 1'b1; p_s_data = 16'h010A; p_s_last = 1'b1;
    tick();
    p_s_valid = 1'b0; p_s_last = 1'b0;
    guard = 0;
    while (pkt_out.size() < 11 && guard < 40) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check("pkt_count", 32'(pkt_out.size()), 32'(11));
    for (int i = 0; i < 11 && i < pkt_out.size(); i++)
      check("pkt_word", 32'(pkt_out[i]), 32'({i == 10, 16'(16'h0100 + i)}));
    check("pkt_empty", 32'(p_empty), 32'(1));
    check("pkt_valid_off", 32'(p_m_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
